myproject_mul_share_arbiter: RTL and testbench
==============================================

// Module: myproject_mul_share_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer that shares one 19s x 19s -> 32 signed multiplier between
//  N_REQ requesters, e.g. the layernorm mean/variance/scale stages. Each requester presents an
//  operand pair with valid/ready. The block grants one request per cycle, registers the operands,
//  multiplies, and returns the product tagged with the requester index. Two pipeline stages,
//  stall-on-backpressure.
// PARAMETERS
//  N_REQ   4   number of requesters, 2..8
//  ID_W    2   width of the requester tag; must be >= clog2(N_REQ)
//  A_W     19  operand A width, signed
//  B_W     19  operand B width, signed
//  P_W     32  product width; the low P_W bits of the full product
// PORTS
//  ap_clk      in   1          clock, rising edge
//  ap_rst_n    in   1          asynchronous active-low reset
//  req_valid   in   N_REQ      per-requester request valid
//  req_ready   out  N_REQ      per-requester accept; one-hot or zero
//  req_a       in   N_REQ*A_W  packed operand A; requester i occupies [i*A_W +: A_W]
//  req_b       in   N_REQ*B_W  packed operand B; same packing as req_a
//  resp_valid  out  1          product valid
//  resp_ready  in   1          downstream accepts the product
//  resp_id     out  ID_W       index of the requester that owns resp_data
//  resp_data   out  P_W        signed product, truncated
//  busy        out  1          high when any pipeline stage holds data
// BEHAVIOUR
//  Reset (ap_rst_n=0, async):
//   - s1_valid, resp_valid, resp_id, resp_data, busy all go to 0.
//   - RR pointer last_grant goes to N_REQ-1, so requester 0 has top priority after reset.
//   - req_ready is combinational and is 0 while reset is asserted.
//  Pipeline:
//   - Stage S1 registers a_s1, b_s1, id_s1 and s1_valid.
//   - Stage S2 is the output register: resp_data, resp_id, resp_valid.
//   - adv2 = ~resp_valid | resp_ready. adv1 = ~s1_valid | adv2.
//  Arbitration (combinational):
//   - Search order is last_grant+1, last_grant+2, ... modulo N_REQ.
//   - The first i with req_valid[i]=1 is the winner g.
//   - req_ready[g] = adv1. All other req_ready bits are 0.
//   - Handshake: a request is accepted when req_valid[i] & req_ready[i].
//   - On accept: S1 <= {req_a[g], req_b[g], g, valid=1} and last_grant <= g.
//   - No accept with adv1=1: s1_valid <= 0.
//   - adv1=0: S1 holds and last_grant holds.
//  Multiply:
//   - resp_data = low P_W bits of $signed(a_s1) * $signed(b_s1).
//   - The full product is A_W+B_W bits wide; upper bits are discarded with no saturation.
//   - On adv2: resp_valid <= s1_valid. When s1_valid=1, resp_data and resp_id load from S1.
//   - adv2=0: resp_valid, resp_data and resp_id hold stable until resp_ready=1.
//  Latency and throughput:
//   - Accept in cycle T -> resp_valid=1 in cycle T+2 when resp_ready stays 1.
//   - Throughput is one product per cycle.
//   - At most 2 products are in flight.
//  Fairness: a requester holding valid is granted within N_REQ accepts.
//  Requester obligations:
//   - Once valid is raised, it holds, and operands stay stable until accepted.
//   - The arbiter may switch a pending winner only when last_grant changes.
//  Boundaries:
//   - Single requester: gets every cycle.
//   - req_valid=0 everywhere: no grant and last_grant unchanged.
//   - Output full with resp_ready=0: S1 fills, then req_ready=0 everywhere.
//   - resp_ready rising with S1 full: S1 moves to S2, and a new request is accepted
//     in the same cycle.
//   - Reset mid-operation: in-flight products are dropped and no response is emitted.
//  busy = s1_valid | resp_valid.
// TESTING
//  1 Reset, then req0 a=3 b=-5 with resp_ready=1
//    -> resp_valid at accept+2, resp_id=0, resp_data=32'hFFFFFFF1.
//  2 a=-262144, b=-262144 -> resp_data=32'h00000000 (2^36 truncated).
//    a=b=262143 -> resp_data=32'hFFF80001.
//  3 All 4 requesters valid continuously with distinct operands -> grant/resp_id order
//    0,1,2,3,0,1...; one accept per cycle.
//  4 Hold resp_ready=0 for 5 cycles with req1 and req2 streaming
//    -> resp_data/resp_id stable, exactly 2 accepted, then req_ready=0.
//    Release -> in-order drain, no loss or duplicates.
//  5 Only req3 valid after a grant to req3 -> req3 granted every cycle.
//    Add req0 -> req0 granted next.
//  6 Pulse ap_rst_n low with both stages full
//    -> outputs 0 asynchronously; the next grant goes to req0 first.

Source files
------------

// File: rtl/myproject_mul_share_arbiter.sv
// Round-robin arbiter that shares one signed multiplier between N_REQ requesters.
// Two pipeline stages (operand register, product register) with stall-on-backpressure.
module myproject_mul_share_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2,
    parameter int unsigned A_W   = 19,
    parameter int unsigned B_W   = 19,
    parameter int unsigned P_W   = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*A_W-1:0] req_a,
    input  logic [N_REQ*B_W-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [P_W-1:0]       resp_data,
    output logic                 busy
);
    localparam int unsigned PROD_W = A_W + B_W;

    logic                     r_s1_valid;
    logic signed [A_W-1:0]    r_a_s1;
    logic signed [B_W-1:0]    r_b_s1;
    logic [ID_W-1:0]          r_id_s1;
    logic                     r_resp_valid;
    logic [ID_W-1:0]          r_resp_id;
    logic [P_W-1:0]           r_resp_data;
    logic [ID_W-1:0]          r_last_grant;

    logic                     w_adv1;
    logic                     w_adv2;
    logic                     w_found;
    logic                     w_accept;
    logic [ID_W-1:0]          w_grant;
    logic [N_REQ-1:0]         w_grant_oh;
    logic [A_W-1:0]           w_a;
    logic [B_W-1:0]           w_b;
    logic signed [PROD_W-1:0] w_prod;
    int unsigned              w_lg;

    assign w_adv2 = ~r_resp_valid | resp_ready;
    assign w_adv1 = ~r_s1_valid | w_adv2;

    // Two passes: indices above last_grant first, then wrap around to 0..last_grant.
    always_comb begin
        w_found    = 1'b0;
        w_grant    = '0;
        w_grant_oh = '0;
        w_a        = '0;
        w_b        = '0;
        w_lg       = 32'(r_last_grant);
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i] && (i > w_lg)) begin
                w_found       = 1'b1;
                w_grant       = ID_W'(i);
                w_grant_oh[i] = 1'b1;
                w_a           = req_a[i*A_W +: A_W];
                w_b           = req_b[i*B_W +: B_W];
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!w_found && req_valid[i] && (i <= w_lg)) begin
                w_found       = 1'b1;
                w_grant       = ID_W'(i);
                w_grant_oh[i] = 1'b1;
                w_a           = req_a[i*A_W +: A_W];
                w_b           = req_b[i*B_W +: B_W];
            end
        end
    end

    assign req_ready = w_grant_oh & {N_REQ{w_adv1 & ap_rst_n}};
    assign w_accept  = w_found & w_adv1;
    assign w_prod    = r_a_s1 * r_b_s1;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_a_s1       <= '0;
            r_b_s1       <= '0;
            r_id_s1      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_last_grant <= ID_W'(N_REQ - 1);
        end else begin
            if (w_adv1) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_a_s1       <= w_a;
                    r_b_s1       <= w_b;
                    r_id_s1      <= w_grant;
                    r_last_grant <= w_grant;
                end
            end
            if (w_adv2) begin
                r_resp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_resp_data <= w_prod[P_W-1:0];
                    r_resp_id   <= r_id_s1;
                end
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign busy       = r_s1_valid | r_resp_valid;

endmodule

// File: tb/tb_myproject_mul_share_arbiter.sv
// Directed bench for the shared-multiplier arbiter: reset, truncation, round-robin,
// backpressure, single-requester and mid-flight reset scenarios.
module tb_myproject_mul_share_arbiter;
    localparam int AW = 19;
    localparam int BW = 19;

    logic              ap_clk = 1'b0;
    logic              ap_rst_n = 1'b0;
    logic [3:0]        req_valid = '0;
    logic [3:0]        req_ready;
    logic [4*AW-1:0]   req_a = '0;
    logic [4*BW-1:0]   req_b = '0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic [1:0]        resp_id;
    logic [31:0]       resp_data;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    myproject_mul_share_arbiter #(
        .N_REQ(4), .ID_W(2), .A_W(AW), .B_W(BW), .P_W(32)
    ) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_id   (resp_id),
        .resp_data (resp_data),
        .busy      (busy)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int i, input int a, input int b);
        req_a[i*AW +: AW] = AW'(a);
        req_b[i*BW +: BW] = BW'(b);
    endtask

    task automatic tick;
        @(posedge ap_clk);
        #1;
    endtask

    task automatic apply_reset;
        ap_rst_n   = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        ap_rst_n   = 1'b0;
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        n_tests++;
        if ({resp_valid, busy, resp_id, resp_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {resp_valid, busy, resp_id, resp_data});
        end
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0000", req_ready);
        end
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        req_valid = '0;
        tick();
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic;
        set_op(0, 3, -5);
        req_valid  = 4'b0001;
        resp_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL basic_ready: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if ({resp_valid, busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_s1: got %b expected 01", {resp_valid, busy});
        end
        tick();
        n_tests++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 32'hFFFFFFF1}) begin
            n_fail++;
            $display("FAIL basic_resp: got %b/%0d/%h expected 1/0/fffffff1",
                     resp_valid, resp_id, resp_data);
        end
        tick();
        n_tests++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL basic_idle: got %b expected 00", {resp_valid, busy});
        end
    endtask

    task automatic test_truncation;
        int          ids[2];
        int          ops[2];
        logic [31:0] exp_d[2];
        ids   = '{0, 2};
        ops   = '{-262144, 262143};
        exp_d = '{32'h00000000, 32'hFFF80001};
        resp_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            set_op(ids[t], ops[t], ops[t]);
            req_valid = 4'(1 << ids[t]);
            #1;
            n_tests++;
            if (req_ready !== 4'(1 << ids[t])) begin
                n_fail++;
                $display("FAIL trunc_ready%0d: got %b expected %b", t, req_ready, 4'(1 << ids[t]));
            end
            tick();
            req_valid = '0;
            tick();
            n_tests++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'(ids[t]), exp_d[t]}) begin
                n_fail++;
                $display("FAIL trunc_resp%0d: got %b/%0d/%h expected 1/%0d/%h",
                         t, resp_valid, resp_id, resp_data, ids[t], exp_d[t]);
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_d[4];
        exp_d = '{32'd300, 32'd800, 32'd1500, 32'd2400};
        apply_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 100 * (i + 1), i + 3);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c < 8) ? 4'hF : 4'h0;
            #1;
            if (c < 8) begin
                n_tests++;
                if (req_ready !== 4'(1 << (c % 4))) begin
                    n_fail++;
                    $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready, 4'(1 << (c % 4)));
                end
            end
            n_tests++;
            if (c >= 2) begin
                if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'((c - 2) % 4), exp_d[(c - 2) % 4]}) begin
                    n_fail++;
                    $display("FAIL rr_resp c%0d: got %b/%0d/%h expected 1/%0d/%h", c, resp_valid,
                             resp_id, resp_data, (c - 2) % 4, exp_d[(c - 2) % 4]);
                end
            end else if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_resp c%0d: got valid %b expected 0", c, resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        int          q_id[$];
        logic [31:0] q_d[$];
        int          n1 = 0;
        int          n2 = 0;
        int          acc = 0;
        int          rsp = 0;
        logic [3:0]  hs;
        resp_ready = 1'b0;
        set_op(1, 10, 2);
        set_op(2, -20, 3);
        req_valid = 4'b0110;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (c >= 2) begin
                n_tests++;
                if (req_ready !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL bp_ready c%0d: got %b expected 0000", c, req_ready);
                end
                n_tests++;
                if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd1, 32'd20}) begin
                    n_fail++;
                    $display("FAIL bp_hold c%0d: got %b/%0d/%h expected 1/1/14",
                             c, resp_valid, resp_id, resp_data);
                end
            end
            hs = req_valid & req_ready;
            if (hs[1]) begin q_id.push_back(1); q_d.push_back(32'(20 + 2 * n1)); n1++; acc++; end
            if (hs[2]) begin q_id.push_back(2); q_d.push_back(32'(-(60 + 3 * n2))); n2++; acc++; end
            tick();
            set_op(1, 10 + n1, 2);
            set_op(2, -(20 + n2), 3);
        end
        n_tests++;
        if (acc !== 2) begin
            n_fail++;
            $display("FAIL bp_accepts: got %0d expected 2", acc);
        end
        resp_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c == 0) begin
                n_tests++;
                if (req_ready !== 4'b0010) begin
                    n_fail++;
                    $display("FAIL bp_release_accept: got %b expected 0010", req_ready);
                end
            end
            if (resp_valid === 1'b1) begin
                rsp++;
                n_tests++;
                if (q_id.size() == 0) begin
                    n_fail++;
                    $display("FAIL bp_drain_extra: got id %0d expected no response", resp_id);
                end else begin
                    if ({resp_id, resp_data} !== {2'(q_id[0]), q_d[0]}) begin
                        n_fail++;
                        $display("FAIL bp_drain: got %0d/%h expected %0d/%h",
                                 resp_id, resp_data, q_id[0], q_d[0]);
                    end
                    void'(q_id.pop_front());
                    void'(q_d.pop_front());
                end
            end
            hs = req_valid & req_ready;
            if (hs[1]) begin q_id.push_back(1); q_d.push_back(32'(20 + 2 * n1)); n1++; acc++; end
            if (hs[2]) begin q_id.push_back(2); q_d.push_back(32'(-(60 + 3 * n2))); n2++; acc++; end
            tick();
            set_op(1, 10 + n1, 2);
            set_op(2, -(20 + n2), 3);
            if (c >= 5) req_valid = req_valid & ~hs;
        end
        n_tests++;
        if ((q_id.size() !== 0) || (rsp !== acc) || (busy !== 1'b0)) begin
            n_fail++;
            $display("FAIL bp_complete: got left=%0d rsp=%0d acc=%0d busy=%b expected left=0 rsp=acc busy=0",
                     q_id.size(), rsp, acc, busy);
        end
    endtask

    task automatic test_single_requester;
        logic [3:0]  vt[13];
        int          gt[13];
        logic [31:0] pe[4];
        logic [3:0]  exp_r;
        vt = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1001, 4'b1001, 4'b0001,
               4'b0000, 4'b0000, 4'b1010, 4'b1000, 4'b0000, 4'b0000};
        gt = '{3, 3, 3, 3, 0, 3, 0, -1, -1, 1, 3, -1, -1};
        pe = '{32'hFFFFFFE0, 32'hFFFFF448, 32'h00000000, 32'h0000001E};
        set_op(0, -4, 8);
        set_op(1, 1000, -3);
        set_op(3, 5, 6);
        resp_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            req_valid = vt[c];
            #1;
            exp_r = (gt[c] >= 0) ? 4'(1 << gt[c]) : 4'b0000;
            n_tests++;
            if (req_ready !== exp_r) begin
                n_fail++;
                $display("FAIL single_grant c%0d: got %b expected %b", c, req_ready, exp_r);
            end
            n_tests++;
            if ((c >= 2) && (gt[c - 2] >= 0)) begin
                if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'(gt[c - 2]), pe[gt[c - 2]]}) begin
                    n_fail++;
                    $display("FAIL single_resp c%0d: got %b/%0d/%h expected 1/%0d/%h", c, resp_valid,
                             resp_id, resp_data, gt[c - 2], pe[gt[c - 2]]);
                end
            end else if (resp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL single_resp c%0d: got valid %b expected 0", c, resp_valid);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight;
        resp_ready = 1'b0;
        set_op(2, 7, 7);
        req_valid = 4'b0100;
        tick();
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if ({busy, resp_valid} !== 2'b11) begin
            n_fail++;
            $display("FAIL mid_full: got %b expected 11", {busy, resp_valid});
        end
        #1;
        ap_rst_n  = 1'b0;
        req_valid = 4'b1001;
        #1;
        n_tests++;
        if ({resp_valid, busy, resp_id, resp_data} !== 36'h0) begin
            n_fail++;
            $display("FAIL mid_async: got %h expected 0", {resp_valid, busy, resp_id, resp_data});
        end
        n_tests++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_ready: got %b expected 0000", req_ready);
        end
        @(negedge ap_clk);
        ap_rst_n   = 1'b1;
        resp_ready = 1'b1;
        set_op(0, 2, 3);
        #1;
        n_tests++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_no_stale: got %b expected 0", resp_valid);
        end
        tick();
        n_tests++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 32'd6}) begin
            n_fail++;
            $display("FAIL mid_resp: got %b/%0d/%h expected 1/0/6", resp_valid, resp_id, resp_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_truncation();
        test_round_robin();
        test_backpressure();
        test_single_requester();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
